load_store_unit: RTL and testbench

- Memory-access stage directly downstream of the ALU in the multi-cycle core.
- Takes the ALU effective address plus the rs2 store data and executes RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) over the single-port word-wide RAM.
- Sub-word stores use read-modify-write. Loads return the sign- or zero-extended result to the control unit for writeback.
- The control unit pulses start_i in its memory stage and stalls until done_o.

---
 rtl/load_store_unit.sv | 170 +++++++++++++++++
 tb/tb_load_store_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit for the multi-cycle RV32I core.
// Executes LB/LH/LW/LBU/LHU/SB/SH/SW over a single-port, word-wide RAM.
// Sub-word stores are done as read-modify-write.
//
// Handshake: the control unit pulses start_i for one cycle while busy_o=0;
// the request is captured on that edge and the unit runs until done_o
// pulses for exactly one cycle (fault_o qualifies it). A start_i seen while
// busy_o=1, including the DONE cycle, is dropped.
module load_store_unit #(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        fault_o,
    output logic [31:0] rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        MERGE = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      state, state_nx;
    logic [31:0] addr_q;
    logic [31:0] data_q;     // store data, replaced by the merged word in MERGE
    logic [2:0]  funct3_q;
    logic        store_q;
    logic        fault_q;

    logic        f3_legal;
    logic        misaligned;
    logic        fault_req;
    logic [31:0] addr_cap;
    logic [31:0] shifted;
    logic [15:0] half_sel;
    logic [31:0] load_ext;
    logic [31:0] merged;

    // Decode the incoming request: legality, alignment and captured address.
    always_comb begin
        f3_legal   = 1'b0;
        misaligned = 1'b0;
        addr_cap   = addr_i;
        if (is_store_i)
            f3_legal = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010);
        else
            f3_legal = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                       (funct3_i == 3'b100) || (funct3_i == 3'b101);
        if (funct3_i[1:0] == 2'b01) begin
            misaligned = addr_i[0];
            if (!ALIGN_CHECK) addr_cap = {addr_i[31:1], 1'b0};
        end else if (funct3_i[1:0] == 2'b10) begin
            misaligned = (addr_i[1:0] != 2'b00);
            if (!ALIGN_CHECK) addr_cap = {addr_i[31:2], 2'b00};
        end
        fault_req = !f3_legal || (ALIGN_CHECK && misaligned);
    end

    // Lane selection and extension for loads; lane replacement for stores.
    always_comb begin
        shifted  = mem_data_i >> {addr_q[1:0], 3'b000};
        half_sel = addr_q[1] ? mem_data_i[31:16] : mem_data_i[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_ext = {24'd0, shifted[7:0]};
            3'b101:  load_ext = {16'd0, half_sel};
            default: load_ext = mem_data_i;
        endcase
        merged = mem_data_i;
        if (funct3_q[1:0] == 2'b00)
            merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
        else
            merged[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state and bus outputs; everything idle outside READ/WRITE/DONE.
    always_comb begin
        state_nx   = state;
        busy_o     = (state != IDLE);
        done_o     = 1'b0;
        fault_o    = 1'b0;
        mem_req_o  = 1'b0;
        mem_we_o   = 1'b0;
        mem_addr_o = 32'd0;
        mem_data_o = 32'd0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    if (fault_req)
                        state_nx = DONE;
                    else if (is_store_i && funct3_i == 3'b010)
                        state_nx = WRITE;
                    else
                        state_nx = READ;
                end
            end
            READ: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {addr_q[31:2], 2'b00};
                state_nx   = MERGE;
            end
            MERGE: begin
                state_nx = store_q ? WRITE : DONE;
            end
            WRITE: begin
                mem_req_o  = 1'b1;
                mem_we_o   = 1'b1;
                mem_addr_o = {addr_q[31:2], 2'b00};
                mem_data_o = data_q;
                state_nx   = DONE;
            end
            DONE: begin
                done_o   = 1'b1;
                fault_o  = fault_q;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Request capture, store merge and registered load result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q   <= 32'd0;
            data_q   <= 32'd0;
            funct3_q <= 3'd0;
            store_q  <= 1'b0;
            fault_q  <= 1'b0;
            rdata_o  <= 32'd0;
        end else begin
            if (state == IDLE && start_i) begin
                addr_q   <= addr_cap;
                data_q   <= wdata_i;
                funct3_q <= funct3_i;
                store_q  <= is_store_i;
                fault_q  <= fault_req;
            end
            if (state == MERGE) begin
                if (store_q) data_q  <= merged;
                else         rdata_o <= load_ext;
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: one instance with alignment checking,
// one without, sharing a simple word RAM model with one-cycle read latency.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        start_a = 1'b0, start_b = 1'b0;

    logic        busy_a, done_a, fault_a, req_a, we_a;
    logic [31:0] rdata_a, maddr_a, mdout_a, mdin_a;
    logic [2:0]  state_a;
    logic        busy_b, done_b, fault_b, req_b, we_b;
    logic [31:0] rdata_b, maddr_b, mdout_b, mdin_b;
    logic [2:0]  state_b;

    logic [31:0] ram [0:255];
    logic        bd_we = 1'b0;
    logic [7:0]  bd_idx = 8'd0;
    logic [31:0] bd_data = 32'd0;

    int n_checks = 0;
    int n_fail = 0;
    int we_cnt = 0, req_cnt = 0, done_cnt = 0, done_b_cnt = 0;
    logic [31:0] last_waddr = 32'd0, last_wdata = 32'd0;

    // Clock and reset.
    always #5 clk = ~clk;

    load_store_unit #(.ALIGN_CHECK(1'b1)) u_dut (
        .clk(clk), .reset(reset), .start_i(start_a), .is_store_i(is_store),
        .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata), .busy_o(busy_a),
        .done_o(done_a), .fault_o(fault_a), .rdata_o(rdata_a), .mem_req_o(req_a),
        .mem_we_o(we_a), .mem_addr_o(maddr_a), .mem_data_i(mdin_a),
        .mem_data_o(mdout_a), .state_o(state_a)
    );

    load_store_unit #(.ALIGN_CHECK(1'b0)) u_dut_na (
        .clk(clk), .reset(reset), .start_i(start_b), .is_store_i(is_store),
        .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata), .busy_o(busy_b),
        .done_o(done_b), .fault_o(fault_b), .rdata_o(rdata_b), .mem_req_o(req_b),
        .mem_we_o(we_b), .mem_addr_o(maddr_b), .mem_data_i(mdin_b),
        .mem_data_o(mdout_b), .state_o(state_b)
    );

    // RAM model: backdoor writes, writes from the checked instance, registered reads.
    always @(posedge clk) begin
        if (bd_we) ram[bd_idx] <= bd_data;
        if (req_a && we_a) ram[maddr_a[9:2]] <= mdout_a;
        mdin_a <= ram[maddr_a[9:2]];
        mdin_b <= ram[maddr_b[9:2]];
    end

    // Bus activity monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (req_a) req_cnt <= req_cnt + 1;
        if (we_a) begin
            we_cnt     <= we_cnt + 1;
            last_waddr <= maddr_a;
            last_wdata <= mdout_a;
        end
        if (done_a) done_cnt <= done_cnt + 1;
        if (done_b) done_b_cnt <= done_b_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic ram_poke(input logic [7:0] idx, input logic [31:0] val);
        @(negedge clk);
        bd_we = 1'b1; bd_idx = idx; bd_data = val;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // Issue one request to instance sel (0: checked, 1: unchecked) and wait for done.
    task automatic do_access(input bit sel, input bit st, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             output int lat, output logic flt,
                             output int we_d, output int req_d, output int done_d);
        int we0, req0, done0;
        @(negedge clk);
        #1;
        we0 = we_cnt; req0 = req_cnt; done0 = sel ? done_b_cnt : done_cnt;
        is_store = st; funct3 = f3; addr = a; wdata = wd;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0; start_b = 1'b0;
        // Inputs change after capture; they must not matter.
        is_store = 1'($urandom_range(0, 1)); funct3 = 3'($urandom_range(0, 7));
        addr = $urandom; wdata = $urandom;
        lat = 1;
        while (!(sel ? done_b : done_a) && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        flt = sel ? fault_b : fault_a;
        @(posedge clk);
        #1;
        @(negedge clk);
        #1;
        we_d = we_cnt - we0; req_d = req_cnt - req0;
        done_d = (sel ? done_b_cnt : done_cnt) - done0;
    endtask

    initial begin
        int lat, we_d, req_d, done_d, we0, done0;
        logic flt;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_done", {31'd0, done_a}, 32'd0);
        check("rst_fault", {31'd0, fault_a}, 32'd0);
        check("rst_req", {31'd0, req_a}, 32'd0);
        check("rst_we", {31'd0, we_a}, 32'd0);
        check("rst_rdata", rdata_a, 32'd0);
        check("rst_maddr", maddr_a, 32'd0);
        check("rst_mdata", mdout_a, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        ram_poke(8'h40, 32'h8899AABB);
        ram_poke(8'h41, 32'h00000000);

        // Loads.
        do_access(0, 0, 3'b000, 32'h101, 32'h0, lat, flt, we_d, req_d, done_d);
        check("lb_lat", lat, 3);
        check("lb_rdata", rdata_a, 32'hFFFFFFAA);
        check("lb_fault", {31'd0, flt}, 32'd0);
        check("lb_no_write", we_d, 0);
        check("lb_one_done", done_d, 1);
        do_access(0, 0, 3'b101, 32'h102, 32'h0, lat, flt, we_d, req_d, done_d);
        check("lhu_rdata", rdata_a, 32'h00008899);
        do_access(0, 0, 3'b001, 32'h102, 32'h0, lat, flt, we_d, req_d, done_d);
        check("lh_rdata", rdata_a, 32'hFFFF8899);
        do_access(0, 0, 3'b010, 32'h100, 32'h0, lat, flt, we_d, req_d, done_d);
        check("lw_rdata", rdata_a, 32'h8899AABB);
        check("lw_lat", lat, 3);
        do_access(0, 0, 3'b100, 32'h100, 32'h0, lat, flt, we_d, req_d, done_d);
        check("lbu_rdata", rdata_a, 32'h000000BB);
        do_access(0, 0, 3'b001, 32'h100, 32'h0, lat, flt, we_d, req_d, done_d);
        check("lh_lo_rdata", rdata_a, 32'hFFFFAABB);

        // Sub-word and word stores.
        do_access(0, 1, 3'b000, 32'h103, 32'h123456CC, lat, flt, we_d, req_d, done_d);
        check("sb_lat", lat, 4);
        check("sb_one_write", we_d, 1);
        check("sb_waddr", last_waddr, 32'h100);
        check("sb_wdata", last_wdata, 32'hCC99AABB);
        check("sb_ram", ram[8'h40], 32'hCC99AABB);
        check("sb_rdata_kept", rdata_a, 32'hFFFFAABB);
        do_access(0, 1, 3'b001, 32'h102, 32'hFFFF1234, lat, flt, we_d, req_d, done_d);
        check("sh_lat", lat, 4);
        check("sh_ram", ram[8'h40], 32'h1234AABB);
        do_access(0, 1, 3'b010, 32'h104, 32'hDEADBEEF, lat, flt, we_d, req_d, done_d);
        check("sw_lat", lat, 2);
        check("sw_one_write", we_d, 1);
        check("sw_waddr", last_waddr, 32'h104);
        check("sw_ram", ram[8'h41], 32'hDEADBEEF);

        // Faults.
        do_access(0, 0, 3'b010, 32'h102, 32'h0, lat, flt, we_d, req_d, done_d);
        check("mis_lat", lat, 1);
        check("mis_fault", {31'd0, flt}, 32'd1);
        check("mis_no_req", req_d, 0);
        check("mis_rdata_kept", rdata_a, 32'hFFFFAABB);
        do_access(0, 0, 3'b001, 32'h101, 32'h0, lat, flt, we_d, req_d, done_d);
        check("mis_lh_fault", {31'd0, flt}, 32'd1);
        do_access(0, 1, 3'b100, 32'h100, 32'h55, lat, flt, we_d, req_d, done_d);
        check("st_f3_fault", {31'd0, flt}, 32'd1);
        check("st_f3_no_req", req_d, 0);
        check("st_f3_ram", ram[8'h40], 32'h1234AABB);
        do_access(0, 0, 3'b011, 32'h100, 32'h0, lat, flt, we_d, req_d, done_d);
        check("ld_f3_fault", {31'd0, flt}, 32'd1);
        do_access(0, 0, 3'b000, 32'h103, 32'h0, lat, flt, we_d, req_d, done_d);
        check("lb_hi_fault", {31'd0, flt}, 32'd0);
        check("lb_hi_rdata", rdata_a, 32'h00000012);

        // Unchecked instance: low address bits cleared instead of faulting.
        do_access(1, 0, 3'b010, 32'h102, 32'h0, lat, flt, we_d, req_d, done_d);
        check("na_lw_fault", {31'd0, flt}, 32'd0);
        check("na_lw_lat", lat, 3);
        check("na_lw_rdata", rdata_b, 32'h1234AABB);
        do_access(1, 0, 3'b001, 32'h103, 32'h0, lat, flt, we_d, req_d, done_d);
        check("na_lh_rdata", rdata_b, 32'h00001234);

        // Reset during the WRITE cycle of an SB aborts the write.
        ram_poke(8'h40, 32'h11223344);
        @(negedge clk);
        #1;
        we0 = we_cnt;
        is_store = 1'b1; funct3 = 3'b000; addr = 32'h100; wdata = 32'h000000EE;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rw_in_write", {31'd0, we_a}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rw_we_drop", {31'd0, we_a}, 32'd0);
        check("rw_busy_drop", {31'd0, busy_a}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rw_ram_kept", ram[8'h40], 32'h11223344);

        // start_i while busy and during DONE is dropped.
        @(negedge clk);
        #1;
        we0 = we_cnt; done0 = done_cnt;
        is_store = 1'b0; funct3 = 3'b010; addr = 32'h104; wdata = 32'h0;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        @(negedge clk);
        is_store = 1'b1; funct3 = 3'b010; addr = 32'h108; wdata = 32'hCAFEF00D;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        @(posedge clk);
        #1;
        check("bz_in_done", {31'd0, done_a}, 32'd1);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        #1;
        check("bz_one_done", done_cnt - done0, 1);
        check("bz_no_write", we_cnt - we0, 0);
        check("bz_rdata", rdata_a, 32'hDEADBEEF);
        check("bz_idle", {31'd0, busy_a}, 32'd0);
        check("bz_ram_108", ram[8'h42] === 32'hCAFEF00D ? 32'd1 : 32'd0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
